// File: rtl/seg_display_scheduler.sv
// Display-ownership arbiter and digit scanner for the 4-digit 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks a leading zero for the time and stopwatch owners.
module seg_display_scheduler #(
  parameter int BLANK_SCANS = 4,
  parameter int BLINK_DIV   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_scan,
  input  logic        tick_blink,
  input  logic [3:0]  req,
  input  logic        count_valid,
  input  logic        alarm_flash,
  input  logic [15:0] num_time,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  input  logic [15:0] num3,
  input  logic [15:0] num4,
  input  logic [3:0]  edit_sel1,
  input  logic [3:0]  edit_sel2,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [2:0]  owner,
  output logic        switching
);

  localparam logic [0:0] SHOW = 1'b0;
  localparam logic [0:0] GAP  = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [1:0] scan_idx_q, scan_idx_d;
  logic       blink_phase_q, blink_phase_d;
  logic [7:0] blink_div_q, blink_div_d;
  logic [3:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d;

  logic [2:0]  candidate;
  logic [15:0] src_bus;
  logic [3:0]  nibble;
  logic        blink_off;
  logic        lead_blank;
  logic [6:0]  seg_dec;

  always_comb begin
    candidate = 3'd0;
    if (req[3])                        candidate = 3'd1;
    else if (req[2])                   candidate = 3'd2;
    else if (req[1])                   candidate = 3'd3;
    else if (req[0] && count_valid)    candidate = 3'd4;
  end

  always_comb begin
    case (owner_q)
      3'd1:    src_bus = num1;
      3'd2:    src_bus = num2;
      3'd3:    src_bus = num3;
      3'd4:    src_bus = num4;
      default: src_bus = num_time;
    endcase
    case (scan_idx_q)
      2'd0:    nibble = src_bus[3:0];
      2'd1:    nibble = src_bus[7:4];
      2'd2:    nibble = src_bus[11:8];
      default: nibble = src_bus[15:12];
    endcase
  end

  always_comb begin
    case (nibble)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  always_comb begin
    blink_off = 1'b0;
    if (!blink_phase_q) begin
      if (owner_q == 3'd1 && edit_sel1[scan_idx_q]) blink_off = 1'b1;
      if (owner_q == 3'd2 && edit_sel2[scan_idx_q]) blink_off = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign lead_blank = (owner_q == 3'd0 || owner_q == 3'd3) &&
                      (scan_idx_q == 2'd3) && (nibble == 4'd0);
`else
  assign lead_blank = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    gap_cnt_d     = gap_cnt_q;
    scan_idx_d    = scan_idx_q;
    blink_phase_d = blink_phase_q;
    blink_div_d   = blink_div_q;
    anode_d       = anode_q;
    seg_d         = seg_q;

    if (tick_blink) begin
      if (blink_div_q == 8'(BLINK_DIV - 1)) begin
        blink_div_d   = 8'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_div_d = blink_div_q + 8'd1;
      end
    end

    case (state_q)
      SHOW: begin
        if (candidate != owner_q) begin
          state_d   = GAP;
          owner_d   = candidate;
          gap_cnt_d = 4'(BLANK_SCANS);
          anode_d   = 4'b1111;
        end else if (tick_scan) begin
          // Outputs show the current index; the index then points at the next digit.
          scan_idx_d = scan_idx_q + 2'd1;
          anode_d    = blink_off ? 4'b1111 : ~(4'b0001 << scan_idx_q);
          if (alarm_flash)     seg_d = 7'b0000000;
          else if (lead_blank) seg_d = 7'b1111111;
          else                 seg_d = seg_dec;
        end
      end
      default: begin
        anode_d = 4'b1111;
        if (candidate != owner_q) begin
          owner_d   = candidate;
          gap_cnt_d = 4'(BLANK_SCANS);
        end else if (tick_scan) begin
          if (gap_cnt_q <= 4'd1) begin
            state_d    = SHOW;
            gap_cnt_d  = 4'd0;
            scan_idx_d = 2'd0;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SHOW;
      owner_q       <= 3'd0;
      gap_cnt_q     <= 4'd0;
      scan_idx_q    <= 2'd0;
      blink_phase_q <= 1'b1;
      blink_div_q   <= 8'd0;
      anode_q       <= 4'b1111;
      seg_q         <= 7'b1111111;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      gap_cnt_q     <= gap_cnt_d;
      scan_idx_q    <= scan_idx_d;
      blink_phase_q <= blink_phase_d;
      blink_div_q   <= blink_div_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
    end
  end

  assign anode     = anode_q;
  assign seg       = seg_q;
  assign owner     = owner_q;
  assign switching = (state_q == GAP);

endmodule
